// File: rtl/reg_wb_queue_if.sv
// Upstream write-request channel into reg_wb_queue: valid/ready handshake
// carrying a destination register index and an 8-bit value.
interface reg_wb_queue_if #(
  parameter int unsigned AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [7:0]    in_data;

  modport master (
    output in_valid,
    output in_addr,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_addr,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/reg_wb_queue.sv
// Write-back queue feeding the 8-bit register bank: FIFO of (addr, data) with a
// registered one-hot drain stage. Define WB_FWD_EN to build the read-forwarding port.
module reg_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREG  = 8,
  parameter int unsigned AW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  reg_wb_queue_if.slave   wb,
  input  logic            hold,
  input  logic            flush,
  output logic [NREG-1:0] wr_en,
  output logic [7:0]      wr_d,
  output logic [AW:0]     count,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_hit,
  output logic [7:0]      rd_data
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]   addr_q [DEPTH];
  logic [AW-1:0]   addr_d [DEPTH];
  logic [7:0]      data_q [DEPTH];
  logic [7:0]      data_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [AW:0]     count_q, count_d;
  logic [NREG-1:0] wr_en_q, wr_en_d;
  logic [7:0]      wr_d_q, wr_d_d;
  logic            push, pop;

  // Readiness depends only on occupancy, so a full queue never accepts even
  // when it drains in the same cycle.
  assign wb.in_ready = (count_q < DEPTH_C);

  always_comb begin
    push    = wb.in_valid && wb.in_ready && !flush;
    pop     = (count_q != '0) && !hold && !flush;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_en_d = '0;
    wr_d_d  = wr_d_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        addr_d[tail_q] = wb.in_addr;
        data_d[tail_q] = wb.in_data;
        tail_d         = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
        wr_d_d = data_q[head_q];
        // Out-of-range addresses still drain but enable nothing.
        if (32'(addr_q[head_q]) < NREG)
          wr_en_d = {{(NREG-1){1'b0}}, 1'b1} << addr_q[head_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wr_en_q <= '0;
      wr_d_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wr_en_q <= wr_en_d;
      wr_d_q  <= wr_d_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign wr_en = wr_en_q;
  assign wr_d  = wr_d_q;
  assign count = count_q;

`ifdef WB_FWD_EN
  logic [PW-1:0] idx;

  // Output stage is oldest, so it is applied first; queue entries are then
  // visited oldest to youngest and the last match overrides.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    idx     = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (wr_en_q[r] && (32'(rd_addr) == r)) begin
        rd_hit  = 1'b1;
        rd_data = wr_d_q;
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((i < 32'(count_q)) && (addr_q[idx] == rd_addr)) begin
        rd_hit  = 1'b1;
        rd_data = data_q[idx];
      end
    end
  end
`else
  logic fwd_unused;

  assign fwd_unused = ^rd_addr;
  assign rd_hit     = 1'b0;
  assign rd_data    = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: cycle model of the queue plus a
// scoreboard of expected bank writes, compared after every rising edge.
module tb_reg_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NREG  = 6;
  localparam int unsigned AW    = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            hold;
  logic            flush;
  logic [NREG-1:0] wr_en;
  logic [7:0]      wr_d;
  logic [AW:0]     count;
  logic [AW-1:0]   rd_addr;
  logic            rd_hit;
  logic [7:0]      rd_data;

  reg_wb_queue_if #(.AW(AW)) bus ();

  reg_wb_queue #(.DEPTH(DEPTH), .NREG(NREG), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wb      (bus),
    .hold    (hold),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_d    (wr_d),
    .count   (count),
    .rd_addr (rd_addr),
    .rd_hit  (rd_hit),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  ent_t        mq[$];   // model of queue contents
  ent_t        sb[$];   // expected bank writes, in order
  logic [7:0]  last_d;
  logic        out_v;
  logic [AW-1:0] out_a;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    int   n;
    bit   do_push, do_pop, exp_fire, exp_hit;
    ent_t e;
    logic [7:0] exp_rd;
    logic [31:0] one;
    n        = mq.size();
    do_push  = bus.in_valid && (n < DEPTH) && !flush && !rst;
    do_pop   = (n > 0) && !hold && !flush && !rst;
    e.addr   = bus.in_addr;
    e.data   = bus.in_data;
    @(posedge clk);
    #1;
    exp_fire = 1'b0;
    if (rst) begin
      mq.delete(); sb.delete(); last_d = 8'h00; out_v = 1'b0;
    end else if (flush) begin
      mq.delete(); sb.delete(); out_v = 1'b0;
    end else begin
      out_v = 1'b0;
      if (do_pop) begin
        ent_t p;
        p        = mq.pop_front();
        last_d   = p.data;
        out_v    = (32'(p.addr) < NREG);
        out_a    = p.addr;
        exp_fire = out_v;
      end
      if (do_push) begin
        mq.push_back(e);
        if (32'(e.addr) < NREG) sb.push_back(e);
      end
    end

    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    chk("wr_d", 32'(wr_d), 32'(last_d));
    chk("wr_fire", 32'(wr_en != '0), 32'(exp_fire));
    if (wr_en != '0) begin
      chk("onehot", 32'($onehot(wr_en)), 32'd1);
      if (sb.size() == 0) begin
        chk("spurious_wr", 32'(wr_en), 32'd0);
      end else begin
        ent_t s;
        s   = sb.pop_front();
        one = 32'd1;
        chk("wr_en", 32'(wr_en), one << s.addr);
        chk("wr_data", 32'(wr_d), 32'(s.data));
      end
    end

    exp_hit = 1'b0;
    exp_rd  = 8'h00;
`ifdef WB_FWD_EN
    if (out_v && out_a == rd_addr) begin
      exp_hit = 1'b1; exp_rd = last_d;
    end
    foreach (mq[i]) begin
      if (mq[i].addr == rd_addr) begin
        exp_hit = 1'b1; exp_rd = mq[i].data;
      end
    end
`endif
    chk("rd_hit", 32'(rd_hit), 32'(exp_hit));
    chk("rd_data", 32'(rd_data), 32'(exp_rd));
  endtask

  task automatic cyc(input logic v, input logic [AW-1:0] a, input logic [7:0] d,
                     input logic h, input logic f);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    hold         = h;
    flush        = f;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; rd_addr = '0;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = 8'h00;
    last_d = 8'h00; out_v = 1'b0; out_a = '0;
    step();
    step();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;

    // single write, 2-cycle latency
    rd_addr = 3'd2;
    cyc(1'b1, 3'd2, 8'hA5, 1'b0, 1'b0);
    cyc(1'b0, '0, 8'h00, 1'b0, 1'b0);
    chk("lat_wr_en", 32'(wr_en), 32'h04);
    chk("lat_wr_d", 32'(wr_d), 32'hA5);
    idle(2);

    // hold while pushing 5: only 4 fit
    for (int i = 0; i < 5; i++) cyc(1'b1, 3'(i), 8'(8'h30 + i), 1'b1, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    idle(6);

    // continuous streaming into a full queue
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'(i + 1), 8'(8'h40 + i), 1'b1, 1'b0);
    for (int i = 0; i < 12; i++)
      cyc(1'b1, 3'($urandom_range(0, 5)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    idle(6);

    // forwarding: youngest value for the same address wins
    rd_addr = 3'd3;
    cyc(1'b1, 3'd3, 8'h11, 1'b1, 1'b0);
    cyc(1'b1, 3'd3, 8'h22, 1'b1, 1'b0);
    cyc(1'b0, '0, 8'h00, 1'b1, 1'b0);
    idle(4);

    // flush with a simultaneous push drops everything
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'(i), 8'(8'h50 + i), 1'b1, 1'b0);
    cyc(1'b1, 3'd4, 8'h99, 1'b0, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_wr_en", 32'(wr_en), 32'd0);
    idle(4);

    // out-of-range addresses drain silently
    rd_addr = 3'd7;
    cyc(1'b1, 3'd7, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 3'd6, 8'hEE, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 8'hDD, 1'b0, 1'b0);
    idle(4);

    // reset in the middle of a drain
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'(i), 8'(8'h60 + i), 1'b1, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    idle(2);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      rd_addr = 3'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
          8'($urandom_range(0, 255)), 1'($urandom_range(0, 9) < 3),
          1'($urandom_range(0, 49) == 0));
    end
    idle(8);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
